// File: rtl/if_fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: word width, NOP encoding, fetch FSM states.
package if_fetch_stage_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_INSTR = 16'h0800;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  // One fetched instruction together with its return address.
  typedef struct packed {
    word_t instr;
    word_t pc2;
  } fetch_dat_t;

  function automatic fetch_dat_t bubble_dat();
    fetch_dat_t d;
    d.instr = NOP_INSTR;
    d.pc2   = '0;
    return d;
  endfunction

endpackage

// File: rtl/cla16b.sv
// 16-bit carry-lookahead adder: 4-bit groups with lookahead across groups; sum wraps at 16 bits.
// Pure combinational, no flow control.
module cla16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  cb;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    cb = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    cb[0] = cin;
    for (int k = 0; k < 4; k++) begin
      cb[k+1] = gg[k] | (pg[k] & cb[k]);
    end
    // Group carries come from the lookahead chain; bits inside a group ripple.
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 0) c[i] = cb[i/4];
      else              c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    sum  = p ^ c;
    cout = cb[4];
  end

endmodule

// File: rtl/if_skid_buf.sv
// Single-entry skid buffer for a fetched instruction; load/drain next edge, clear wins over load.
// No backpressure of its own: caller must not load while full unless draining.
module if_skid_buf
  import if_fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       drain,
  input  logic       clear,
  input  fetch_dat_t in_dat,
  output logic       skid_vld,
  output fetch_dat_t skid_dat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld <= 1'b0;
      skid_dat <= bubble_dat();
    end else if (clear) begin
      skid_vld <= 1'b0;
    end else if (load) begin
      skid_vld <= 1'b1;
      skid_dat <= in_dat;
    end else if (drain) begin
      skid_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch into IF/ID: 1-cycle on memory hit, PcStall held while a fetch is outstanding.
// Decode stall parks one completed fetch in a skid buffer; IF_STALL_CNT_EN adds IfStallCnt.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC,
  input  logic        Flush,
  input  logic        IdStall,
  input  logic        MemDone,
  input  logic        MemStall,
  input  logic [15:0] MemData,
  output logic        MemRd,
  output logic [15:0] MemAddr,
  output logic        PcStall,
  output logic [15:0] IfId_Instr,
  output logic [15:0] IfId_PC2,
  output logic        IfId_Valid
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0] IfStallCnt
`endif
);

  fetch_state_t state;
  word_t        addr_q;
  logic         kill;
  logic         done;
  logic         accept;
  word_t        pc2_nxt;
  logic         pc2_cout;
  logic         skid_vld;
  fetch_dat_t   skid_dat;
  fetch_dat_t   mem_dat;
  logic         unused_sink;

  // A new fetch may only start when the skid has room for its result.
  always_comb begin
    MemRd   = (state == WAIT) || (!skid_vld && !Flush);
    MemAddr = (state == WAIT) ? addr_q : PC;
    done    = MemRd && MemDone;
    accept  = done && !kill && !Flush;
    PcStall = !accept;
    mem_dat.instr = MemData;
    mem_dat.pc2   = pc2_nxt;
  end

  cla16b u_pc2_add (
    .a    (MemAddr),
    .b    (16'd2),
    .cin  (1'b0),
    .sum  (pc2_nxt),
    .cout (pc2_cout)
  );

  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && IdStall),
    .drain    (!Flush && !IdStall && skid_vld),
    .clear    (Flush),
    .in_dat   (mem_dat),
    .skid_vld (skid_vld),
    .skid_dat (skid_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      kill       <= 1'b0;
      IfId_Instr <= NOP_INSTR;
      IfId_PC2   <= '0;
      IfId_Valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MemRd) begin
            addr_q <= PC;
            if (!MemDone) state <= WAIT;
          end
        end
        WAIT: begin
          if (MemDone) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A flush that lands mid-fetch poisons only that fetch's eventual return.
      if (done) kill <= 1'b0;
      else if (Flush && (state == WAIT)) kill <= 1'b1;

      if (Flush) begin
        IfId_Instr <= NOP_INSTR;
        IfId_PC2   <= '0;
        IfId_Valid <= 1'b0;
      end else if (!IdStall) begin
        if (skid_vld) begin
          IfId_Instr <= skid_dat.instr;
          IfId_PC2   <= skid_dat.pc2;
          IfId_Valid <= 1'b1;
        end else if (accept) begin
          IfId_Instr <= MemData;
          IfId_PC2   <= pc2_nxt;
          IfId_Valid <= 1'b1;
        end else begin
          IfId_Instr <= NOP_INSTR;
          IfId_PC2   <= '0;
          IfId_Valid <= 1'b0;
        end
      end
    end
  end

`ifdef IF_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IfStallCnt <= '0;
    end else if (((MemRd && !MemDone) || MemStall) && (IfStallCnt != 16'hFFFF)) begin
      IfStallCnt <= IfStallCnt + 16'd1;
    end
  end
`endif

  assign unused_sink = &{1'b0, MemStall, pc2_cout};

endmodule
